// File: rtl/dp_dmi_pkg.sv
// Shared types and helpers for the DMI sequencing controller (dp_dmi_ctrl).
// Holds op/status/state encodings plus the sticky-status merge helpers.
package dp_dmi_pkg;

    localparam int DMI_ABITS = 7;

    typedef enum logic [1:0] {
        NOP   = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RSVD  = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        OK     = 2'd0,
        FAILED = 2'd2,
        BUSY   = 2'd3
    } dmi_stat_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } ctrl_state_e;

    // Sticky status only ever climbs: OK(0) < FAILED(2) < BUSY(3).
    function automatic logic [1:0] stat_merge(input logic [1:0] cur, input logic [1:0] ev);
        return (ev > cur) ? ev : cur;
    endfunction

    function automatic logic [1:0] rsp_to_stat(input logic [1:0] rsp_op);
        logic [1:0] st;
        case (rsp_op)
            2'd2:    st = FAILED;
            2'd3:    st = BUSY;
            default: st = OK;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/dp_dmi_watchdog.sv
// Cycle counter with clear and an expire flag; used for the DM response
// timeout when DP_DMI_TIMEOUT_EN is defined.
module dp_dmi_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic iclk,
    input  logic iresetn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;

    // Expires during the LIMIT-th enabled cycle so the abort lands on that edge.
    assign expired = en && (cnt_r == CW'(LIMIT - 1));

    // Next count: hold at the limit, restart on clear or when idle.
    always_comb begin
        cnt_s = cnt_r;
        if (clr || !en) begin
            cnt_s = '0;
        end else if (!expired) begin
            cnt_s = cnt_r + CW'(1);
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Count register.
    always_ff @(posedge iclk) begin
        if (!iresetn) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_s;
        end
    end

endmodule

// File: rtl/dp_dmi_ctrl.sv
// DMI access sequencer between the DTM and the debug module valid/ready bus.
// Optional DM response timeout is built when DP_DMI_TIMEOUT_EN is defined.
module dp_dmi_ctrl
    import dp_dmi_pkg::*;
#(
    parameter int ABITS = DMI_ABITS
`ifdef DP_DMI_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 255
`endif
) (
    input  logic             iclk,
    input  logic             iresetn,
    input  logic             dmi_update,
    input  logic [ABITS-1:0] dmi_address,
    input  logic [31:0]      dmi_wdata,
    input  logic [1:0]       dmi_op,
    input  logic             dmireset,
    input  logic             dmihardreset,
    output logic [31:0]      dmi_rdata,
    output logic [1:0]       dmi_resp,
    output logic [1:0]       dmistat,
    output logic             dm_req_valid,
    input  logic             dm_req_ready,
    output logic [ABITS-1:0] dm_req_addr,
    output logic [31:0]      dm_req_data,
    output logic [1:0]       dm_req_op,
    input  logic             dm_rsp_valid,
    output logic             dm_rsp_ready,
    input  logic [31:0]      dm_rsp_data,
    input  logic [1:0]       dm_rsp_op
);

    ctrl_state_e      state_r, state_s;
    logic             req_valid_r, req_valid_s;
    logic             rsp_ready_r, rsp_ready_s;
    logic [ABITS-1:0] req_addr_r, req_addr_s;
    logic [31:0]      req_data_r, req_data_s;
    dmi_op_e          req_op_r, req_op_s;
    logic [31:0]      rdata_r, rdata_s;
    logic [1:0]       resp_r, resp_s;
    logic [1:0]       stat_r, stat_s;
    logic [1:0]       stat_base_s;
    logic [1:0]       stat_ev_s;
    logic             busy_err_s;
    logic             timeout_s;

`ifdef DP_DMI_TIMEOUT_EN
    dp_dmi_watchdog #(
        .LIMIT(TIMEOUT_CYC)
    ) u_watchdog (
        .iclk   (iclk),
        .iresetn(iresetn),
        .clr    ((state_s != state_r) || dmihardreset),
        .en     (state_r != IDLE),
        .expired(timeout_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // dmireset acts before anything else this cycle, so an update alongside it sees a clean status.
    assign stat_base_s = dmireset ? 2'(OK) : stat_r;
    assign busy_err_s  = dmi_update && (state_r != IDLE) && (dmi_op != NOP);

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_s     = state_r;
        req_valid_s = req_valid_r;
        rsp_ready_s = rsp_ready_r;
        req_addr_s  = req_addr_r;
        req_data_s  = req_data_r;
        req_op_s    = req_op_r;
        rdata_s     = rdata_r;
        resp_s      = resp_r;
        stat_ev_s   = OK;
        stat_s      = stat_base_s;
        if (dmihardreset) begin
            state_s     = IDLE;
            req_valid_s = 1'b0;
            rsp_ready_s = 1'b0;
            req_addr_s  = '0;
            req_data_s  = 32'd0;
            req_op_s    = NOP;
            rdata_s     = 32'd0;
            resp_s      = OK;
            stat_s      = OK;
        end else begin
            case (state_r)
                IDLE: begin
                    if (dmi_update && (dmi_op == READ || dmi_op == WRITE) && (stat_base_s == OK)) begin
                        state_s     = REQ;
                        req_valid_s = 1'b1;
                        req_addr_s  = dmi_address;
                        req_data_s  = dmi_wdata;
                        req_op_s    = dmi_op_e'(dmi_op);
                    end else if (dmi_update) begin
                        resp_s = stat_base_s;
                    end else begin
                        resp_s = resp_r;
                    end
                end
                REQ: begin
                    if (timeout_s) begin
                        state_s     = IDLE;
                        req_valid_s = 1'b0;
                        resp_s      = FAILED;
                        stat_ev_s   = FAILED;
                    end else if (dm_req_ready) begin
                        state_s     = RSP;
                        req_valid_s = 1'b0;
                        rsp_ready_s = 1'b1;
                    end else begin
                        req_valid_s = 1'b1;
                    end
                end
                RSP: begin
                    if (timeout_s) begin
                        state_s     = IDLE;
                        rsp_ready_s = 1'b0;
                        resp_s      = FAILED;
                        stat_ev_s   = FAILED;
                    end else if (dm_rsp_valid && rsp_ready_r) begin
                        state_s     = IDLE;
                        rsp_ready_s = 1'b0;
                        rdata_s     = (req_op_r == READ) ? dm_rsp_data : rdata_r;
                        resp_s      = dm_rsp_op;
                        stat_ev_s   = rsp_to_stat(dm_rsp_op);
                    end else begin
                        rsp_ready_s = 1'b1;
                    end
                end
                default: begin
                    state_s     = IDLE;
                    req_valid_s = 1'b0;
                    rsp_ready_s = 1'b0;
                end
            endcase
            // An overlapping update always reports busy, even if the response lands this cycle.
            resp_s = busy_err_s ? 2'(BUSY) : resp_s;
            stat_s = stat_merge(stat_merge(stat_base_s, stat_ev_s), busy_err_s ? 2'(BUSY) : 2'(OK));
        end
    end

    // State and output registers.
    always_ff @(posedge iclk) begin
        if (!iresetn) begin
            state_r     <= IDLE;
            req_valid_r <= 1'b0;
            rsp_ready_r <= 1'b0;
            req_addr_r  <= '0;
            req_data_r  <= 32'd0;
            req_op_r    <= NOP;
            rdata_r     <= 32'd0;
            resp_r      <= 2'd0;
            stat_r      <= 2'd0;
        end else begin
            state_r     <= state_s;
            req_valid_r <= req_valid_s;
            rsp_ready_r <= rsp_ready_s;
            req_addr_r  <= req_addr_s;
            req_data_r  <= req_data_s;
            req_op_r    <= req_op_s;
            rdata_r     <= rdata_s;
            resp_r      <= resp_s;
            stat_r      <= stat_s;
        end
    end

    assign dmi_rdata    = rdata_r;
    assign dmi_resp     = resp_r;
    assign dmistat      = stat_r;
    assign dm_req_valid = req_valid_r;
    assign dm_rsp_ready = rsp_ready_r;
    assign dm_req_addr  = req_addr_r;
    assign dm_req_data  = req_data_r;
    assign dm_req_op    = req_op_r;

endmodule

// File: tb/tb_dp_dmi_ctrl.sv
// Directed self-checking bench for dp_dmi_ctrl; the timeout scenario is
// compiled only when DP_DMI_TIMEOUT_EN is defined (TIMEOUT_CYC=8).
module tb_dp_dmi_ctrl;

    logic        iclk = 1'b0;
    logic        iresetn;
    logic        dmi_update;
    logic [6:0]  dmi_address;
    logic [31:0] dmi_wdata;
    logic [1:0]  dmi_op;
    logic        dmireset;
    logic        dmihardreset;
    logic [31:0] dmi_rdata;
    logic [1:0]  dmi_resp;
    logic [1:0]  dmistat;
    logic        dm_req_valid;
    logic        dm_req_ready;
    logic [6:0]  dm_req_addr;
    logic [31:0] dm_req_data;
    logic [1:0]  dm_req_op;
    logic        dm_rsp_valid;
    logic        dm_rsp_ready;
    logic [31:0] dm_rsp_data;
    logic [1:0]  dm_rsp_op;

    int checks   = 0;
    int failures = 0;

    always #5 iclk = ~iclk;

    dp_dmi_ctrl #(
        .ABITS(7)
`ifdef DP_DMI_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(8)
`endif
    ) dut (
        .iclk(iclk), .iresetn(iresetn), .dmi_update(dmi_update), .dmi_address(dmi_address),
        .dmi_wdata(dmi_wdata), .dmi_op(dmi_op), .dmireset(dmireset), .dmihardreset(dmihardreset),
        .dmi_rdata(dmi_rdata), .dmi_resp(dmi_resp), .dmistat(dmistat),
        .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_addr(dm_req_addr),
        .dm_req_data(dm_req_data), .dm_req_op(dm_req_op), .dm_rsp_valid(dm_rsp_valid),
        .dm_rsp_ready(dm_rsp_ready), .dm_rsp_data(dm_rsp_data), .dm_rsp_op(dm_rsp_op)
    );

    task automatic tick();
        @(posedge iclk);
        @(negedge iclk);
    endtask

    task automatic update(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wd);
        dmi_update  = 1'b1;
        dmi_op      = op;
        dmi_address = addr;
        dmi_wdata   = wd;
    endtask

    task automatic test_reset();
        iresetn = 1'b0; dmireset = 1'b0; dmihardreset = 1'b0;
        dm_req_ready = 1'b1; dm_rsp_valid = 1'b1; dm_rsp_data = 32'hFFFF_FFFF; dm_rsp_op = 2'd3;
        update(2'd1, 7'h7F, 32'hFFFF_FFFF);
        tick(); tick();
        checks++;
        if ({dm_req_valid, dm_rsp_ready, dmistat, dmi_resp, dm_req_op} !== 8'd0) begin
            failures++;
            $display("FAIL reset_ctrl got %b exp 0", {dm_req_valid, dm_rsp_ready, dmistat, dmi_resp, dm_req_op});
        end
        checks++;
        if ({dmi_rdata, dm_req_addr, dm_req_data} !== 71'd0) begin
            failures++;
            $display("FAIL reset_data got rdata=%h addr=%h data=%h exp 0", dmi_rdata, dm_req_addr, dm_req_data);
        end
        dmi_update = 1'b0; dmi_op = 2'd0; dm_rsp_valid = 1'b0;
        iresetn = 1'b1;
        tick();
    endtask

    task automatic test_read();
        int cyc;
        dm_req_ready = 1'b1; dm_rsp_valid = 1'b1; dm_rsp_data = 32'hDEAD_BEEF; dm_rsp_op = 2'd0;
        update(2'd1, 7'h10, 32'd0);
        tick();
        dmi_update = 1'b0; dmi_op = 2'd0;
        checks++;
        if ({dm_req_valid, dm_req_addr, dm_req_op} !== {1'b1, 7'h10, 2'd1}) begin
            failures++;
            $display("FAIL read_req got v=%b a=%h op=%0d exp v=1 a=10 op=1", dm_req_valid, dm_req_addr, dm_req_op);
        end
        cyc = 1;
        while ((dm_req_valid === 1'b1 || dm_rsp_ready === 1'b1) && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc != 3) begin
            failures++;
            $display("FAIL read_latency got %0d exp 3", cyc);
        end
        checks++;
        if ({dmi_rdata, dmi_resp, dmistat} !== {32'hDEAD_BEEF, 2'd0, 2'd0}) begin
            failures++;
            $display("FAIL read_result got rdata=%h resp=%0d stat=%0d exp deadbeef 0 0", dmi_rdata, dmi_resp, dmistat);
        end
        dm_rsp_valid = 1'b0;
    endtask

    task automatic test_write_stall();
        logic stable;
        dm_req_ready = 1'b0; dm_rsp_valid = 1'b0;
        update(2'd2, 7'h04, 32'h0000_0001);
        tick();
        dmi_update = 1'b0; dmi_op = 2'd0; dmi_wdata = 32'hA5A5_A5A5;
        checks++;
        if ({dm_req_valid, dm_req_addr, dm_req_data, dm_req_op} !== {1'b1, 7'h04, 32'h1, 2'd2}) begin
            failures++;
            $display("FAIL write_req got v=%b a=%h d=%h op=%0d exp 1 04 1 2", dm_req_valid, dm_req_addr, dm_req_data, dm_req_op);
        end
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if ({dm_req_valid, dm_req_addr, dm_req_data, dm_req_op} !== {1'b1, 7'h04, 32'h1, 2'd2}) stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin
            failures++;
            $display("FAIL write_hold got stable=%b exp 1", stable);
        end
        dm_req_ready = 1'b1;
        tick();
        dm_req_ready = 1'b0;
        checks++;
        if ({dm_req_valid, dm_rsp_ready} !== 2'b01) begin
            failures++;
            $display("FAIL write_handshake got v=%b rr=%b exp 0 1", dm_req_valid, dm_rsp_ready);
        end
        dm_rsp_valid = 1'b1; dm_rsp_op = 2'd0; dm_rsp_data = 32'h5555_5555;
        tick();
        dm_rsp_valid = 1'b0;
        checks++;
        if ({dm_rsp_ready, dmi_resp, dmistat, dmi_rdata} !== {1'b0, 2'd0, 2'd0, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL write_done got rr=%b resp=%0d stat=%0d rdata=%h exp 0 0 0 deadbeef", dm_rsp_ready, dmi_resp, dmistat, dmi_rdata);
        end
    endtask

    task automatic test_busy_overlap();
        dm_req_ready = 1'b1; dm_rsp_valid = 1'b0;
        update(2'd1, 7'h20, 32'd0);
        tick();
        dmi_update = 1'b0;
        tick();
        update(2'd1, 7'h30, 32'd0);
        tick();
        dmi_update = 1'b0;
        checks++;
        if ({dm_req_valid, dmistat, dmi_resp} !== {1'b0, 2'd3, 2'd3}) begin
            failures++;
            $display("FAIL busy_overlap got v=%b stat=%0d resp=%0d exp 0 3 3", dm_req_valid, dmistat, dmi_resp);
        end
        dm_rsp_valid = 1'b1; dm_rsp_data = 32'h1234_5678; dm_rsp_op = 2'd0;
        tick();
        dm_rsp_valid = 1'b0;
        checks++;
        if ({dmi_rdata, dmi_resp, dmistat} !== {32'h1234_5678, 2'd0, 2'd3}) begin
            failures++;
            $display("FAIL busy_inflight got rdata=%h resp=%0d stat=%0d exp 12345678 0 3", dmi_rdata, dmi_resp, dmistat);
        end
        update(2'd1, 7'h11, 32'd0);
        tick();
        dmi_update = 1'b0;
        checks++;
        if ({dm_req_valid, dmi_resp} !== {1'b0, 2'd3}) begin
            failures++;
            $display("FAIL busy_drop got v=%b resp=%0d exp 0 3", dm_req_valid, dmi_resp);
        end
        dmireset = 1'b1;
        tick();
        dmireset = 1'b0;
        checks++;
        if (dmistat !== 2'd0) begin
            failures++;
            $display("FAIL busy_dmireset got %0d exp 0", dmistat);
        end
        dm_rsp_valid = 1'b1; dm_rsp_data = 32'hCAFE_F00D;
        update(2'd1, 7'h11, 32'd0);
        tick();
        dmi_update = 1'b0;
        checks++;
        if ({dm_req_valid, dm_req_addr} !== {1'b1, 7'h11}) begin
            failures++;
            $display("FAIL busy_accept got v=%b a=%h exp 1 11", dm_req_valid, dm_req_addr);
        end
        tick(); tick();
        dm_rsp_valid = 1'b0;
        checks++;
        if (dmi_rdata !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL busy_accept_data got %h exp cafef00d", dmi_rdata);
        end
    endtask

    task automatic test_fail_rsp();
        dm_req_ready = 1'b1; dm_rsp_valid = 1'b1; dm_rsp_op = 2'd2; dm_rsp_data = 32'h0BAD_BAD0;
        update(2'd1, 7'h12, 32'd0);
        tick();
        dmi_update = 1'b0;
        tick(); tick();
        dm_rsp_op = 2'd0;
        checks++;
        if ({dmistat, dmi_resp, dmi_rdata} !== {2'd2, 2'd2, 32'h0BAD_BAD0}) begin
            failures++;
            $display("FAIL fail_rsp got stat=%0d resp=%0d rdata=%h exp 2 2 0badbad0", dmistat, dmi_resp, dmi_rdata);
        end
        update(2'd2, 7'h04, 32'h9);
        tick();
        dmi_update = 1'b0;
        checks++;
        if ({dm_req_valid, dmi_resp} !== {1'b0, 2'd2}) begin
            failures++;
            $display("FAIL fail_drop got v=%b resp=%0d exp 0 2", dm_req_valid, dmi_resp);
        end
        tick();
        checks++;
        if ({dm_req_valid, dm_rsp_ready, dmistat} !== {1'b0, 1'b0, 2'd2}) begin
            failures++;
            $display("FAIL fail_idle got v=%b rr=%b stat=%0d exp 0 0 2", dm_req_valid, dm_rsp_ready, dmistat);
        end
        dmireset = 1'b1; dm_rsp_data = 32'h1313_1313;
        update(2'd1, 7'h13, 32'd0);
        tick();
        dmireset = 1'b0; dmi_update = 1'b0;
        checks++;
        if ({dm_req_valid, dm_req_addr, dmistat} !== {1'b1, 7'h13, 2'd0}) begin
            failures++;
            $display("FAIL reset_and_update got v=%b a=%h stat=%0d exp 1 13 0", dm_req_valid, dm_req_addr, dmistat);
        end
        tick(); tick();
        dm_rsp_valid = 1'b0;
        checks++;
        if ({dmi_rdata, dmi_resp} !== {32'h1313_1313, 2'd0}) begin
            failures++;
            $display("FAIL reset_and_update_data got rdata=%h resp=%0d exp 13131313 0", dmi_rdata, dmi_resp);
        end
    endtask

    task automatic test_hardreset();
        dm_req_ready = 1'b1; dm_rsp_valid = 1'b0;
        update(2'd1, 7'h14, 32'd0);
        tick();
        dmi_update = 1'b0;
        tick();
        checks++;
        if (dm_rsp_ready !== 1'b1) begin
            failures++;
            $display("FAIL hard_in_rsp got %b exp 1", dm_rsp_ready);
        end
        update(2'd2, 7'h15, 32'd0);
        tick();
        dmi_update = 1'b0;
        dmihardreset = 1'b1;
        tick();
        dmihardreset = 1'b0;
        checks++;
        if ({dm_req_valid, dm_rsp_ready, dmistat, dmi_resp, dmi_rdata} !== 38'd0) begin
            failures++;
            $display("FAIL hard_clear got v=%b rr=%b stat=%0d resp=%0d rdata=%h exp all 0", dm_req_valid, dm_rsp_ready, dmistat, dmi_resp, dmi_rdata);
        end
        dm_rsp_valid = 1'b1; dm_rsp_data = 32'hFFFF_FFFF; dm_rsp_op = 2'd2;
        tick(); tick();
        dm_rsp_valid = 1'b0; dm_rsp_op = 2'd0;
        checks++;
        if ({dm_rsp_ready, dmistat, dmi_resp, dmi_rdata} !== 37'd0) begin
            failures++;
            $display("FAIL hard_late_rsp got rr=%b stat=%0d resp=%0d rdata=%h exp all 0", dm_rsp_ready, dmistat, dmi_resp, dmi_rdata);
        end
    endtask

`ifdef DP_DMI_TIMEOUT_EN
    task automatic test_timeout();
        dm_req_ready = 1'b0; dm_rsp_valid = 1'b0;
        update(2'd1, 7'h16, 32'd0);
        tick();
        dmi_update = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if ({dm_req_valid, dmistat} !== {1'b1, 2'd0}) begin
            failures++;
            $display("FAIL timeout_early got v=%b stat=%0d exp 1 0", dm_req_valid, dmistat);
        end
        tick();
        checks++;
        if ({dm_req_valid, dm_rsp_ready, dmistat, dmi_resp} !== {1'b0, 1'b0, 2'd2, 2'd2}) begin
            failures++;
            $display("FAIL timeout_abort got v=%b rr=%b stat=%0d resp=%0d exp 0 0 2 2", dm_req_valid, dm_rsp_ready, dmistat, dmi_resp);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL tb_timeout got no finish exp finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read();
        test_write_stall();
        test_busy_overlap();
        test_fail_rsp();
        test_hardreset();
`ifdef DP_DMI_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
